// File: rtl/vram_pkg.sv
// Shared constants and enumerations for the sprite VRAM write-port arbiter.
package vram_pkg;

  localparam int LINE_ADDR_W    = 12;
  localparam int WORDS_PER_LINE = 8;
  localparam int WORD_W         = 16;
  localparam int ADDR_W         = LINE_ADDR_W + $clog2(WORDS_PER_LINE);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } vram_wr_state_t;

  typedef enum logic {
    GRANT_CPU  = 1'b0,
    GRANT_LINE = 1'b1
  } vram_requester_t;

endpackage

// File: rtl/vram_write_arbiter.sv
// Shares the sprite VRAM write port between single CPU word writes and
// 8-word sprite-line bursts, round-robin per transaction, only while write_allow.
module vram_write_arbiter #(
  parameter int LINE_ADDR_W    = vram_pkg::LINE_ADDR_W,
  parameter int WORDS_PER_LINE = vram_pkg::WORDS_PER_LINE,
  parameter int WORD_W         = vram_pkg::WORD_W,
  parameter int ADDR_W         = LINE_ADDR_W + $clog2(WORDS_PER_LINE)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             write_allow,
  input  logic                             cpu_req,
  input  logic [ADDR_W-1:0]                cpu_addr,
  input  logic [WORD_W-1:0]                cpu_data,
  output logic                             cpu_ack,
  input  logic                             line_req,
  input  logic [LINE_ADDR_W-1:0]           line_addr,
  input  logic [WORD_W*WORDS_PER_LINE-1:0] line_data,
  output logic                             line_busy,
  output logic                             line_ack,
  output logic [ADDR_W-1:0]                vram_write_addr,
  output logic [WORD_W-1:0]                vram_write_data,
  output logic                             vram_write_enable
);
  import vram_pkg::*;

  localparam int IDX_W = $clog2(WORDS_PER_LINE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

  vram_wr_state_t         state_q, state_d;
  vram_requester_t        last_grant_q, last_grant_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [LINE_ADDR_W-1:0] line_addr_q, line_addr_d;
  logic [WORD_W-1:0]      line_words_q [WORDS_PER_LINE];
  logic [WORD_W-1:0]      line_words_d [WORDS_PER_LINE];
  logic                   cpu_ack_q, cpu_ack_d;
  logic                   line_ack_q, line_ack_d;
  logic                   line_busy_q, line_busy_d;
  logic                   we_q, we_d;
  logic [ADDR_W-1:0]      waddr_q, waddr_d;
  logic [WORD_W-1:0]      wdata_q, wdata_d;

  logic cpu_elig;
  logic grant_cpu;
  logic grant_line;

  // A CPU request still visible in its own ack cycle is stale, so it cannot win.
  always_comb begin
    cpu_elig   = cpu_req && !cpu_ack_q;
    grant_cpu  = 1'b0;
    grant_line = 1'b0;
    if (state_q == IDLE && write_allow) begin
      if (cpu_elig && line_req) begin
        grant_cpu  = (last_grant_q == GRANT_LINE);
        grant_line = (last_grant_q == GRANT_CPU);
      end else begin
        grant_cpu  = cpu_elig;
        grant_line = line_req;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    idx_d        = idx_q;
    line_addr_d  = line_addr_q;
    line_words_d = line_words_q;
    cpu_ack_d    = 1'b0;
    line_ack_d   = 1'b0;
    line_busy_d  = line_busy_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (grant_cpu) begin
          we_d         = 1'b1;
          waddr_d      = cpu_addr;
          wdata_d      = cpu_data;
          cpu_ack_d    = 1'b1;
          last_grant_d = GRANT_CPU;
        end else if (grant_line) begin
          line_addr_d = line_addr;
          for (int i = 0; i < WORDS_PER_LINE; i++) begin
            line_words_d[i] = line_data[i*WORD_W +: WORD_W];
          end
          idx_d        = '0;
          line_busy_d  = 1'b1;
          last_grant_d = GRANT_LINE;
          state_d      = BURST;
        end
      end
      BURST: begin
        // Without write_allow the burst simply pauses at the current word.
        if (write_allow) begin
          we_d    = 1'b1;
          waddr_d = {line_addr_q, idx_q};
          wdata_d = line_words_q[idx_q];
          idx_d   = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            line_ack_d  = 1'b1;
            line_busy_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_LINE;
      idx_q        <= '0;
      cpu_ack_q    <= 1'b0;
      line_ack_q   <= 1'b0;
      line_busy_q  <= 1'b0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      idx_q        <= idx_d;
      cpu_ack_q    <= cpu_ack_d;
      line_ack_q   <= line_ack_d;
      line_busy_q  <= line_busy_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Latched line payload is only consumed in BURST, so it needs no reset.
  always_ff @(posedge clk) begin
    line_addr_q  <= line_addr_d;
    line_words_q <= line_words_d;
  end

  assign cpu_ack           = cpu_ack_q;
  assign line_ack          = line_ack_q;
  assign line_busy         = line_busy_q;
  assign vram_write_enable = we_q;
  assign vram_write_addr   = waddr_q;
  assign vram_write_data   = wdata_q;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Scoreboard bench for vram_write_arbiter: per-requester expected write queues
// plus a modelled VRAM that is read back after directed and random traffic.
module tb_vram_write_arbiter;

  localparam int LAW = 12;
  localparam int WPL = 8;
  localparam int WW  = 16;
  localparam int AW  = 15;
  localparam int LW  = WW * WPL;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          write_allow = 1'b0;
  logic          cpu_req = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [WW-1:0] cpu_data = '0;
  logic          line_req = 1'b0;
  logic [LAW-1:0] line_addr = '0;
  logic [LW-1:0] line_data = '0;
  logic          cpu_ack, line_busy, line_ack, vram_write_enable;
  logic [AW-1:0] vram_write_addr;
  logic [WW-1:0] vram_write_data;

  vram_write_arbiter dut (
    .clk(clk), .reset_n(reset_n), .write_allow(write_allow),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
    .line_req(line_req), .line_addr(line_addr), .line_data(line_data),
    .line_busy(line_busy), .line_ack(line_ack),
    .vram_write_addr(vram_write_addr), .vram_write_data(vram_write_data),
    .vram_write_enable(vram_write_enable)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
    logic          last;
  } wr_t;

  wr_t           cpu_q[$];
  wr_t           line_q[$];
  logic [WW-1:0] dut_mem [int];
  logic [WW-1:0] ref_mem [int];
  string         who_log = "";
  int            n_cmp = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            writes_seen = 0;
  logic          wa_at_edge = 1'b0;
  bit            mon_en = 1'b0;
  bit            soak_done = 1'b0;

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    wa_at_edge <= write_allow;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] rd_dut(input int a);
    return dut_mem.exists(a) ? dut_mem[a] : 'x;
  endfunction

  function automatic logic [WW-1:0] rd_ref(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 'x;
  endfunction

  // Monitor: every write strobe is matched against the requester it is acked for.
  wr_t mon_e;
  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      if (cpu_ack && line_ack) check("ack_exclusive", 128'(cpu_ack & line_ack), 128'(0));
      if (vram_write_enable) begin
        writes_seen++;
        check("write_allowed", 128'(wa_at_edge), 128'(1));
        dut_mem[int'(vram_write_addr)] = vram_write_data;
        if (cpu_ack) begin
          who_log = {who_log, "C"};
          if (cpu_q.size() == 0) check("cpu_write_expected", 128'(cpu_q.size()), 128'(1));
          else begin
            mon_e = cpu_q.pop_front();
            check("cpu_addr", 128'(vram_write_addr), 128'(mon_e.addr));
            check("cpu_data", 128'(vram_write_data), 128'(mon_e.data));
          end
        end else begin
          who_log = {who_log, "L"};
          if (line_q.size() == 0) check("line_write_expected", 128'(line_q.size()), 128'(1));
          else begin
            mon_e = line_q.pop_front();
            check("line_addr", 128'(vram_write_addr), 128'(mon_e.addr));
            check("line_data", 128'(vram_write_data), 128'(mon_e.data));
            check("line_ack_on_last", 128'(line_ack), 128'(mon_e.last));
          end
        end
      end else if (cpu_ack || line_ack) begin
        check("ack_has_write", 128'(vram_write_enable), 128'(1));
      end
    end
  end

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [WW-1:0] d, output int lat);
    wr_t e;
    int  wa_cnt;
    e = '{addr: a, data: d, last: 1'b0};
    cpu_q.push_back(e);
    ref_mem[int'(a)] = d;
    cpu_addr = a;
    cpu_data = d;
    cpu_req  = 1'b1;
    lat = 0;
    wa_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (write_allow) wa_cnt++;
      #1;
      lat++;
      if (cpu_ack) break;
    end
    check("cpu_ack_seen", 128'(cpu_ack), 128'(1));
    check("cpu_wait_bound", 128'(wa_cnt <= 10), 128'(1));
    // Registered requester: the request is still up for one edge after the ack.
    wait_edge();
    cpu_req  = 1'b0;
    cpu_addr = AW'($urandom);
    cpu_data = WW'($urandom);
  endtask

  task automatic line_issue(input logic [LAW-1:0] la, input logic [LW-1:0] ld, output int lat);
    wr_t  e;
    logic prev;
    bit   got;
    for (int i = 0; i < WPL; i++) begin
      e.addr = {la, 3'(i)};
      e.data = ld[i*WW +: WW];
      e.last = (i == WPL - 1);
      line_q.push_back(e);
      ref_mem[int'(e.addr)] = e.data;
    end
    line_addr = la;
    line_data = ld;
    line_req  = 1'b1;
    prev = line_busy;
    got  = 1'b0;
    lat  = 0;
    for (int i = 0; i < 400; i++) begin
      wait_edge();
      lat++;
      if (line_busy && !prev) begin
        got = 1'b1;
        break;
      end
      prev = line_busy;
    end
    check("line_latched", 128'(got), 128'(1));
    line_req  = 1'b0;
    line_addr = LAW'($urandom);
    line_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_line_ack(output int cyc_at);
    for (int i = 0; i < 400; i++) begin
      wait_edge();
      if (line_ack) break;
    end
    check("line_ack_seen", 128'(line_ack), 128'(1));
    cyc_at = cyc;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, lat2, t0, t1, w0, cnt, errs;
    logic [LW-1:0] ld, rb, rb_ref;
    int          soak_lines[$];
    int          soak_cpu[$];

    // Reset and idle outputs
    write_allow = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_edge();
      check("reset_outputs", 128'({cpu_ack, line_busy, line_ack, vram_write_enable,
                                   vram_write_addr, vram_write_data}), 128'(0));
    end
    mon_en = 1'b1;

    // Single CPU write
    cpu_write(15'h1234, 16'hBEEF, lat);
    check("cpu_latency", 128'(lat), 128'(1));
    check("cpu_no_double_write", 128'(vram_write_enable), 128'(0));
    check("cpu_ack_one_cycle", 128'(cpu_ack), 128'(0));

    // Line burst into line 5
    ld = {$urandom, $urandom, $urandom, $urandom};
    w0 = writes_seen;
    t0 = cyc;
    line_issue(12'd5, ld, lat);
    check("line_grant_latency", 128'(lat), 128'(1));
    wait_line_ack(t1);
    check("line_ack_latency", 128'(t1 - t0), 128'(9));
    wait_edge();
    check("line_write_count", 128'(writes_seen - w0), 128'(8));
    for (int i = 0; i < WPL; i++) rb[i*WW +: WW] = rd_dut(40 + i);
    check("line5_readback", rb, ld);

    // Burst paused by write_allow after the third word
    ld = {$urandom, $urandom, $urandom, $urandom};
    w0 = writes_seen;
    t0 = cyc;
    line_issue(12'd9, ld, lat);
    cnt = 0;
    for (int i = 0; i < 50 && cnt < 3; i++) begin
      wait_edge();
      if (vram_write_enable) cnt++;
    end
    write_allow = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_edge();
      check("pause_no_write", 128'(vram_write_enable), 128'(0));
    end
    write_allow = 1'b1;
    wait_line_ack(t1);
    check("pause_ack_latency", 128'(t1 - t0), 128'(12));
    wait_edge();
    check("pause_write_count", 128'(writes_seen - w0), 128'(8));

    // Reset in the middle of a burst
    line_issue(12'd11, {$urandom, $urandom, $urandom, $urandom}, lat);
    cnt = 0;
    for (int i = 0; i < 50 && cnt < 3; i++) begin
      wait_edge();
      if (vram_write_enable) cnt++;
    end
    reset_n = 1'b0;
    #1;
    check("abort_we", 128'(vram_write_enable), 128'(0));
    check("abort_busy", 128'(line_busy), 128'(0));
    line_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    w0 = writes_seen;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      wait_edge();
      if (line_ack) cnt++;
    end
    check("abort_no_writes", 128'(writes_seen - w0), 128'(0));
    check("abort_no_ack", 128'(cnt), 128'(0));

    // Contention straight after reset: CPU wins, then the line
    who_log = "";
    ld = {$urandom, $urandom, $urandom, $urandom};
    fork
      cpu_write(15'h4100, WW'($urandom), lat);
      begin
        line_issue(12'd3, ld, lat2);
        wait_line_ack(t1);
      end
    join
    wait_edge();
    check("contention_cpu_latency", 128'(lat), 128'(1));
    check("contention_line_latency", 128'(lat2), 128'(2));
    check_str("contention_order1", who_log, "CLLLLLLLL");

    // Both re-raised during a burst: CPU goes after line_ack, before the next line
    line_issue(12'd6, {$urandom, $urandom, $urandom, $urandom}, lat);
    who_log = "";
    fork
      cpu_write(15'h4200, WW'($urandom), lat);
      begin
        line_issue(12'd7, {$urandom, $urandom, $urandom, $urandom}, lat2);
        wait_line_ack(t1);
      end
    join
    wait_edge();
    check_str("contention_order2", who_log, "LLLLLLLLCLLLLLLLL");

    // Random soak: 128 lines, interleaved CPU writes, random write_allow
    soak_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 128; n++) begin
          int la;
          repeat ($urandom_range(0, 4)) wait_edge();
          la = int'($urandom_range(0, 2047));
          soak_lines.push_back(la);
          line_issue(LAW'(la), {$urandom, $urandom, $urandom, $urandom}, lat2);
        end
        wait_line_ack(t1);
        soak_done = 1'b1;
      end
      begin
        int lat_c;
        while (!soak_done) begin
          int ca;
          repeat ($urandom_range(0, 6)) wait_edge();
          if (soak_done) break;
          ca = 16384 + int'($urandom_range(0, 16383));
          soak_cpu.push_back(ca);
          cpu_write(AW'(ca), WW'($urandom), lat_c);
        end
      end
      begin
        while (!soak_done) begin
          wait_edge();
          write_allow = ($urandom_range(0, 3) != 0);
        end
        write_allow = 1'b1;
      end
    join
    repeat (20) wait_edge();
    check("cpu_q_drained", 128'(cpu_q.size()), 128'(0));
    check("line_q_drained", 128'(line_q.size()), 128'(0));
    foreach (soak_lines[k]) begin
      for (int i = 0; i < WPL; i++) begin
        rb[i*WW +: WW]     = rd_dut(soak_lines[k] * WPL + i);
        rb_ref[i*WW +: WW] = rd_ref(soak_lines[k] * WPL + i);
      end
      check("soak_line_readback", rb, rb_ref);
    end
    errs = 0;
    foreach (soak_cpu[k]) if (rd_dut(soak_cpu[k]) !== rd_ref(soak_cpu[k])) errs++;
    check("soak_cpu_readback_errors", 128'(errs), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
